user_checker: RTL and testbench

USER_CHECKER -- requirements
Module: user_checker

---
 rtl/user_axi_pkg.sv | 23 ++
 rtl/sat_counter.sv | 25 ++
 rtl/user_checker.sv | 173 +++++++++++++++++
 tb/tb_user_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_axi_pkg.sv
// Shared state encodings, command field layout and packet constants
// for the user read-data checker.
package user_axi_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'b0001,
      WAIT_DATA = 4'b0010,
      CHECK     = 4'b0100,
      DONE      = 4'b1000
   } chk_state_t;

   // Length field bit positions, counted from the top of the address field
   localparam int LEN_MSB     = 11;
   localparam int LEN_LSB     = 0;
   localparam int LEN_WIDTH   = LEN_MSB - LEN_LSB + 1;
   localparam int PACKAGE_LEN = 1024;
   localparam int CNT_WIDTH   = 16;

   function automatic logic is_busy(input chk_state_t st);
      return (st == WAIT_DATA) || (st == CHECK);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

   // Count register: clear, saturating increment, or hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != MAX_VAL)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/user_checker.sv
// Checks incrementing read-data packets against their command length and address.
// Optional idle-beat timeout enabled by defining USER_CHECKER_TIMEOUT_EN.
module user_checker
   import user_axi_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH  = 32,
   parameter int USER_DATA_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         user_cmd_ren,
   input  logic [AXI_ADDR_WIDTH+11:0]   user_rd_cmd,
   input  logic                         user_rd_vld,
   input  logic [USER_DATA_WIDTH-1:0]   user_rd_data,
   input  logic                         user_rd_last,
   output logic                         chk_busy,
   output logic                         chk_done,
   output logic                         err_flag,
   output logic [15:0]                  err_cnt,
   output logic [15:0]                  pkt_cnt,
   output logic [AXI_ADDR_WIDTH-1:0]    first_err_addr
);

   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_BYTES = AXI_ADDR_WIDTH'(USER_DATA_WIDTH / 8);

   chk_state_t                 state_r;
   chk_state_t                 state_next_s;
   logic [LEN_WIDTH-1:0]       len_r;
   logic [LEN_WIDTH-1:0]       idx_r;
   logic [USER_DATA_WIDTH-1:0] exp_r;
   logic [AXI_ADDR_WIDTH-1:0]  cur_addr_r;
   logic                       first_err_seen_r;
   logic                       err_flag_r;
   logic [15:0]                pkt_cnt_r;
   logic [AXI_ADDR_WIDTH-1:0]  first_err_addr_r;

   logic [LEN_WIDTH-1:0]       cmd_len_s;
   logic [AXI_ADDR_WIDTH-1:0]  cmd_addr_s;
   logic                       busy_s;
   logic                       beat_s;
   logic                       mismatch_s;
   logic                       last_beat_s;
   logic                       last_err_s;
   logic                       cmd_ok_s;
   logic                       cmd_err_s;
   logic                       stray_s;
   logic                       timeout_s;
   logic                       enter_done_s;

   assign cmd_len_s    = user_rd_cmd[AXI_ADDR_WIDTH+LEN_MSB:AXI_ADDR_WIDTH+LEN_LSB];
   assign cmd_addr_s   = user_rd_cmd[AXI_ADDR_WIDTH-1:0];
   assign busy_s       = is_busy(state_r);
   assign beat_s       = busy_s && user_rd_vld;
   assign mismatch_s   = beat_s && (user_rd_data != exp_r);
   assign last_beat_s  = (idx_r == (len_r - LEN_WIDTH'(1)));
   assign last_err_s   = beat_s && (user_rd_last != last_beat_s);
   assign cmd_ok_s     = (state_r == IDLE) && user_cmd_ren && (cmd_len_s != '0);
   assign cmd_err_s    = user_cmd_ren && ((state_r != IDLE) || (cmd_len_s == '0));
   assign stray_s      = (state_r == IDLE) && user_rd_vld;
   assign enter_done_s = (state_next_s == DONE) && (state_r != DONE);

`ifdef USER_CHECKER_TIMEOUT_EN
   // DONE lands on the same edge where the idle count reaches all-ones
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = 16'hFFFE;
   logic [CNT_WIDTH-1:0] idle_cnt_s;

   sat_counter #(.WIDTH(CNT_WIDTH)) u_idle_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (!busy_s || user_rd_vld),
      .inc   (busy_s && !user_rd_vld),
      .count (idle_cnt_s)
   );

   assign timeout_s = busy_s && !user_rd_vld && (idle_cnt_s == TIMEOUT_LAST);
`else
   assign timeout_s = 1'b0;
`endif

   sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (mismatch_s),
      .count (err_cnt)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; an early or on-time last beat both close the packet
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_ok_s) begin
               state_next_s = WAIT_DATA;
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT_DATA, CHECK: begin
            if (beat_s && (last_beat_s || user_rd_last)) begin
               state_next_s = DONE;
            end else if (timeout_s) begin
               state_next_s = DONE;
            end else if (beat_s) begin
               state_next_s = CHECK;
            end else begin
               state_next_s = state_r;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Packet context: latched on an accepted command, advanced per beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_r      <= '0;
         idx_r      <= '0;
         exp_r      <= '0;
         cur_addr_r <= '0;
      end else if (cmd_ok_s) begin
         len_r      <= cmd_len_s;
         idx_r      <= '0;
         exp_r      <= '0;
         cur_addr_r <= cmd_addr_s;
      end else if (beat_s) begin
         idx_r      <= idx_r + LEN_WIDTH'(1);
         exp_r      <= exp_r + USER_DATA_WIDTH'(1);
         cur_addr_r <= cur_addr_r + BEAT_BYTES;
      end
   end

   // Sticky error flag and first-mismatch address capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flag_r       <= 1'b0;
         first_err_seen_r <= 1'b0;
         first_err_addr_r <= '0;
      end else begin
         err_flag_r <= err_flag_r | cmd_err_s | stray_s | mismatch_s | last_err_s | timeout_s;
         if (mismatch_s && !first_err_seen_r) begin
            first_err_seen_r <= 1'b1;
            first_err_addr_r <= cur_addr_r;
         end
      end
   end

   // Completed-packet counter, bumped on entry to DONE so it lines up with chk_done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt_r <= 16'h0000;
      end else if (enter_done_s) begin
         pkt_cnt_r <= pkt_cnt_r + 16'h0001;
      end
   end

   assign chk_busy       = busy_s;
   assign chk_done       = (state_r == DONE);
   assign err_flag       = err_flag_r;
   assign pkt_cnt        = pkt_cnt_r;
   assign first_err_addr = first_err_addr_r;

endmodule

// File: tb/tb_user_checker.sv
// Directed self-checking bench for user_checker; timeout scenario runs
// only when USER_CHECKER_TIMEOUT_EN is defined.
module tb_user_checker;
   import user_axi_pkg::*;

   logic        clk;
   logic        rst;
   logic        user_cmd_ren;
   logic [43:0] user_rd_cmd;
   logic        user_rd_vld;
   logic [15:0] user_rd_data;
   logic        user_rd_last;
   logic        chk_busy;
   logic        chk_done;
   logic        err_flag;
   logic [15:0] err_cnt;
   logic [15:0] pkt_cnt;
   logic [31:0] first_err_addr;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int done_pulses = 0;

   user_checker #(.AXI_ADDR_WIDTH(32), .USER_DATA_WIDTH(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .user_cmd_ren   (user_cmd_ren),
      .user_rd_cmd    (user_rd_cmd),
      .user_rd_vld    (user_rd_vld),
      .user_rd_data   (user_rd_data),
      .user_rd_last   (user_rd_last),
      .chk_busy       (chk_busy),
      .chk_done       (chk_done),
      .err_flag       (err_flag),
      .err_cnt        (err_cnt),
      .pkt_cnt        (pkt_cnt),
      .first_err_addr (first_err_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chk_done === 1'b1) done_pulses++;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic send_cmd(input logic [11:0] len, input logic [31:0] addr);
      user_cmd_ren = 1'b1;
      user_rd_cmd  = {len, addr};
      step();
      user_cmd_ren = 1'b0;
   endtask

   task automatic send_beat(input logic [15:0] data, input logic last);
      user_rd_vld  = 1'b1;
      user_rd_data = data;
      user_rd_last = last;
      step();
      user_rd_vld  = 1'b0;
      user_rd_last = 1'b0;
   endtask

   task automatic send_stream(input int n, input int bad_idx, input logic [15:0] bad_val,
                              input int last_idx);
      for (int i = 0; i < n; i++) begin
         send_beat((i == bad_idx) ? bad_val : 16'(i), i == last_idx);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      chk_cnt++; if (chk_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", chk_busy); else pass_cnt++;
      chk_cnt++; if (chk_done !== 1'b0) $display("FAIL reset_done: got %b want 0", chk_done); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b0) $display("FAIL reset_err_flag: got %b want 0", err_flag); else pass_cnt++;
      chk_cnt++; if (err_cnt !== 16'h0000) $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); else pass_cnt++;
      chk_cnt++; if (pkt_cnt !== 16'h0000) $display("FAIL reset_pkt_cnt: got %h want 0000", pkt_cnt); else pass_cnt++;
      chk_cnt++; if (first_err_addr !== 32'h0) $display("FAIL reset_first_err_addr: got %h want 0", first_err_addr); else pass_cnt++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_good_packet();
      int start;
      apply_reset();
      start = done_pulses;
      send_cmd(12'(PACKAGE_LEN), 32'h0000_0800);
      chk_cnt++; if (chk_busy !== 1'b1) $display("FAIL good_busy: got %b want 1", chk_busy); else pass_cnt++;
      send_stream(PACKAGE_LEN, -1, 16'h0000, PACKAGE_LEN - 1);
      chk_cnt++; if (chk_done !== 1'b1) $display("FAIL good_done: got %b want 1", chk_done); else pass_cnt++;
      step();
      chk_cnt++; if (chk_done !== 1'b0) $display("FAIL good_done_width: got %b want 0", chk_done); else pass_cnt++;
      chk_cnt++; if (done_pulses - start !== 1) $display("FAIL good_done_pulses: got %0d want 1", done_pulses - start); else pass_cnt++;
      chk_cnt++; if (pkt_cnt !== 16'd1) $display("FAIL good_pkt_cnt: got %0d want 1", pkt_cnt); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b0) $display("FAIL good_err_flag: got %b want 0", err_flag); else pass_cnt++;
      chk_cnt++; if (err_cnt !== 16'd0) $display("FAIL good_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
      chk_cnt++; if (chk_busy !== 1'b0) $display("FAIL good_idle_busy: got %b want 0", chk_busy); else pass_cnt++;
   endtask

   task automatic test_data_error();
      apply_reset();
      send_cmd(12'(PACKAGE_LEN), 32'h0000_0800);
      send_stream(PACKAGE_LEN, 5, 16'hBEEF, PACKAGE_LEN - 1);
      step();
      chk_cnt++; if (err_cnt !== 16'd1) $display("FAIL data_err_cnt: got %0d want 1", err_cnt); else pass_cnt++;
      chk_cnt++; if (first_err_addr !== 32'h0000_080A) $display("FAIL data_first_addr: got %h want 0000080a", first_err_addr); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b1) $display("FAIL data_err_flag: got %b want 1", err_flag); else pass_cnt++;
      // second packet errs at beat 2 of address 0x100; first address must stay
      send_cmd(12'd4, 32'h0000_0100);
      send_stream(4, 2, 16'h0007, 3);
      step();
      chk_cnt++; if (err_cnt !== 16'd2) $display("FAIL data2_err_cnt: got %0d want 2", err_cnt); else pass_cnt++;
      chk_cnt++; if (first_err_addr !== 32'h0000_080A) $display("FAIL data2_first_addr: got %h want 0000080a", first_err_addr); else pass_cnt++;
      chk_cnt++; if (pkt_cnt !== 16'd2) $display("FAIL data2_pkt_cnt: got %0d want 2", pkt_cnt); else pass_cnt++;
   endtask

   task automatic test_early_last();
      apply_reset();
      send_cmd(12'd4, 32'h0000_0000);
      send_stream(3, -1, 16'h0000, 2);
      chk_cnt++; if (chk_done !== 1'b1) $display("FAIL early_done: got %b want 1", chk_done); else pass_cnt++;
      step();
      chk_cnt++; if (err_flag !== 1'b1) $display("FAIL early_err_flag: got %b want 1", err_flag); else pass_cnt++;
      chk_cnt++; if (pkt_cnt !== 16'd1) $display("FAIL early_pkt_cnt: got %0d want 1", pkt_cnt); else pass_cnt++;
      chk_cnt++; if (err_cnt !== 16'd0) $display("FAIL early_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
   endtask

   task automatic test_late_last();
      apply_reset();
      send_cmd(12'd2, 32'h0000_0000);
      send_stream(2, -1, 16'h0000, -1);
      chk_cnt++; if (chk_done !== 1'b1) $display("FAIL late_done: got %b want 1", chk_done); else pass_cnt++;
      step();
      chk_cnt++; if (err_flag !== 1'b1) $display("FAIL late_err_flag: got %b want 1", err_flag); else pass_cnt++;
   endtask

   task automatic test_cmd_mid_packet();
      apply_reset();
      send_cmd(12'd4, 32'h0000_0000);
      send_beat(16'h0000, 1'b0);
      send_cmd(12'd8, 32'h0000_0200);
      chk_cnt++; if (chk_busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", chk_busy); else pass_cnt++;
      for (int i = 1; i < 4; i++) send_beat(16'(i), i == 3);
      chk_cnt++; if (chk_done !== 1'b1) $display("FAIL mid_done: got %b want 1", chk_done); else pass_cnt++;
      step();
      chk_cnt++; if (pkt_cnt !== 16'd1) $display("FAIL mid_pkt_cnt: got %0d want 1", pkt_cnt); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b1) $display("FAIL mid_err_flag: got %b want 1", err_flag); else pass_cnt++;
      chk_cnt++; if (err_cnt !== 16'd0) $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
   endtask

   task automatic test_len_zero();
      apply_reset();
      send_cmd(12'd0, 32'h0000_0010);
      chk_cnt++; if (chk_busy !== 1'b0) $display("FAIL len0_busy: got %b want 0", chk_busy); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b1) $display("FAIL len0_err_flag: got %b want 1", err_flag); else pass_cnt++;
      chk_cnt++; if (pkt_cnt !== 16'd0) $display("FAIL len0_pkt_cnt: got %0d want 0", pkt_cnt); else pass_cnt++;
   endtask

   task automatic test_stray_beat();
      apply_reset();
      send_beat(16'h0003, 1'b0);
      chk_cnt++; if (err_flag !== 1'b1) $display("FAIL stray_err_flag: got %b want 1", err_flag); else pass_cnt++;
      chk_cnt++; if (err_cnt !== 16'd0) $display("FAIL stray_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
      chk_cnt++; if (chk_busy !== 1'b0) $display("FAIL stray_busy: got %b want 0", chk_busy); else pass_cnt++;
   endtask

   task automatic test_reset_mid_packet();
      apply_reset();
      send_cmd(12'(PACKAGE_LEN), 32'h0000_0800);
      send_stream(500, 10, 16'h1234, -1);
      chk_cnt++; if (err_cnt !== 16'd1) $display("FAIL rstmid_pre_err_cnt: got %0d want 1", err_cnt); else pass_cnt++;
      user_rd_vld  = 1'b1;
      user_rd_data = 16'd500;
      #2;
      rst = 1'b1;
      #1;
      chk_cnt++; if (chk_busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", chk_busy); else pass_cnt++;
      chk_cnt++; if (chk_done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", chk_done); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b0) $display("FAIL rstmid_err_flag: got %b want 0", err_flag); else pass_cnt++;
      chk_cnt++; if (err_cnt !== 16'd0) $display("FAIL rstmid_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
      chk_cnt++; if (pkt_cnt !== 16'd0) $display("FAIL rstmid_pkt_cnt: got %0d want 0", pkt_cnt); else pass_cnt++;
      chk_cnt++; if (first_err_addr !== 32'h0) $display("FAIL rstmid_first_addr: got %h want 0", first_err_addr); else pass_cnt++;
      step();
      user_rd_vld = 1'b0;
      rst = 1'b0;
      step();
      send_cmd(12'd4, 32'h0000_0040);
      send_stream(4, -1, 16'h0000, 3);
      step();
      chk_cnt++; if (err_cnt !== 16'd0) $display("FAIL rstmid_after_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b0) $display("FAIL rstmid_after_err_flag: got %b want 0", err_flag); else pass_cnt++;
      chk_cnt++; if (pkt_cnt !== 16'd1) $display("FAIL rstmid_after_pkt_cnt: got %0d want 1", pkt_cnt); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      send_cmd(12'd2, 32'h0000_0000);
      send_stream(2, -1, 16'h0000, 1);
      chk_cnt++; if (chk_done !== 1'b1) $display("FAIL b2b_done: got %b want 1", chk_done); else pass_cnt++;
      send_cmd(12'd2, 32'h0000_0000);
      chk_cnt++; if (chk_busy !== 1'b0) $display("FAIL b2b_drop_busy: got %b want 0", chk_busy); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b1) $display("FAIL b2b_drop_err_flag: got %b want 1", err_flag); else pass_cnt++;
      send_cmd(12'd2, 32'h0000_0000);
      chk_cnt++; if (chk_busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", chk_busy); else pass_cnt++;
      send_stream(2, -1, 16'h0000, 1);
      step();
      chk_cnt++; if (pkt_cnt !== 16'd2) $display("FAIL b2b_pkt_cnt: got %0d want 2", pkt_cnt); else pass_cnt++;
      chk_cnt++; if (err_cnt !== 16'd0) $display("FAIL b2b_err_cnt: got %0d want 0", err_cnt); else pass_cnt++;
   endtask

`ifdef USER_CHECKER_TIMEOUT_EN
   task automatic test_timeout();
      int cycles;
      apply_reset();
      send_cmd(12'd8, 32'h0000_0000);
      send_stream(3, -1, 16'h0000, -1);
      cycles = 0;
      while (chk_done !== 1'b1 && cycles < 70000) begin
         step();
         cycles++;
      end
      chk_cnt++; if (cycles !== 65535) $display("FAIL timeout_cycles: got %0d want 65535", cycles); else pass_cnt++;
      chk_cnt++; if (err_flag !== 1'b1) $display("FAIL timeout_err_flag: got %b want 1", err_flag); else pass_cnt++;
      chk_cnt++; if (pkt_cnt !== 16'd1) $display("FAIL timeout_pkt_cnt: got %0d want 1", pkt_cnt); else pass_cnt++;
   endtask
`endif

   initial begin
      rst          = 1'b1;
      user_cmd_ren = 1'b0;
      user_rd_cmd  = 44'h0;
      user_rd_vld  = 1'b0;
      user_rd_data = 16'h0000;
      user_rd_last = 1'b0;
      test_reset();
      test_good_packet();
      test_data_error();
      test_early_last();
      test_late_last();
      test_cmd_mid_packet();
      test_len_zero();
      test_stray_beat();
      test_reset_mid_packet();
      test_back_to_back();
`ifdef USER_CHECKER_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
